// File: rtl/regfile_cmd_master.sv
// Command-driven initiator for a 4x32 register file: owns both read ports and the write port,
// runs one WRI/RD/ADD/ADDI command at a time and returns the result on a response channel.
module regfile_cmd_master #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWrite, StResp} state_e;

  localparam logic [1:0] OpWri  = 2'b00;
  localparam logic [1:0] OpRd   = 2'b01;
  localparam logic [1:0] OpAdd  = 2'b10;
  localparam logic [1:0] OpAddi = 2'b11;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dst_q, dst_d, src1_q, src1_d, src2_q, src2_d;
  logic [DATA_W-1:0]   imm_q, imm_d, result_q, result_d;
  logic [DATA_W-1:0]   exec_result;

  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;

  always_comb begin
    exec_result = '0;
    unique case (op_q)
      OpWri:  exec_result = imm_q;
      OpRd:   exec_result = ReadData1;
      OpAdd:  exec_result = ReadData1 + ReadData2;
      OpAddi: exec_result = ReadData1 + imm_q;
      default: exec_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    imm_d     = imm_q;
    result_d  = result_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          src1_d  = cmd_src1;
          src2_d  = cmd_src2;
          imm_d   = cmd_imm;
          state_d = StExec;
        end
      end
      StExec: begin
        ReadReg1 = src1_q;
        ReadReg2 = src2_q;
        result_d = exec_result;
        state_d  = (op_q == OpRd) ? StResp : StWrite;
      end
      StWrite: state_d = StResp;
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      dst_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      imm_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      imm_q    <= imm_d;
      result_q <= result_d;
    end
  end

  assign rsp_data = result_q;

  // Write port changes only on the falling edge so the file's RegWrite-gated clock sees
  // stable address/data/enable for the whole high phase of the write cycle.
  always_comb begin
    reg_write_d  = (state_q == StWrite);
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (state_q == StWrite) begin
      write_reg_d  = dst_q;
      write_data_d = result_q;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;

endmodule
